demux_1to2_stream: RTL and testbench
====================================

# demux_1to2_stream

Registered 1-to-2 stream demultiplexer: the return-direction counterpart of the 2:1 mux in the basics library. Each input word with a select bit is routed to output A (select=0) or B (select=1) through a one-entry holding register per output, with valid/ready handshakes on all three ports. A stalled output blocks only traffic addressed to it. Per-output transfer counters support bench checking and debug.

## Interface
- WIDTH, 8, data width of input and both outputs
- CNT_W, 16, width of each transfer counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  WIDTH  input word
- in_sel  in  1  routing select: 0 → A, 1 → B
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- a_data  out  WIDTH  channel A word (registered)
- a_valid  out  1  channel A holding register full
- a_ready  in  1  channel A sink accepts
- b_data  out  WIDTH  channel B word (registered)
- b_valid  out  1  channel B holding register full
- b_ready  in  1  channel B sink accepts
- a_count  out  CNT_W  completed A output transfers, wraps
- b_count  out  CNT_W  completed B output transfers, wraps

## Operation
- Per-channel state machine, two states: EMPTY (x_valid=0), FULL (x_valid=1).
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: x_valid & x_ready at a rising edge.
- in_ready = rst_n & (target slot EMPTY | target slot draining this cycle), target chosen by current in_sel. Combinational from in_sel, x_valid, x_ready.
- EMPTY → FULL: input transfer with in_sel selecting this channel; x_data ← in_data.
- FULL → EMPTY: output transfer and no simultaneous load.
- FULL → FULL: output transfer and simultaneous load; x_data replaced by new word (full throughput, no bubble).
- FULL, no output transfer: x_data and x_valid held stable; input addressed to this channel stalls (in_ready=0).
- Channel independence: A full and stalled does not affect in_ready for words with in_sel=1, and vice versa.
- in_sel and in_data may change freely while in_valid=0 or in_ready=0; only values at an input transfer matter.
- Counters: x_count increments by 1 on each output transfer of that channel; wraps 2^CNT_W−1 → 0. Input transfers do not count.
- No reordering within a channel; ordering across channels is not guaranteed or tracked.

## Timing
- Reset (rst_n=0 at a rising edge): a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0. in_ready=0 whenever rst_n=0.
- Reset mid-operation: held words are discarded; no output transfer is counted on the reset edge even if x_ready=1.
- Latency: word accepted at edge N appears on x_data/x_valid after edge N, available for output transfer at edge N+1.
- Throughput: one word per cycle to the same channel while the sink holds x_ready=1; alternating channels also sustain one word per cycle.
- x_valid never deasserts without an output transfer (except reset); x_data never changes while x_valid=1 and x_ready=0.
- in_valid=1 with in_ready=0: nothing captured; the source holds the word.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, a_ready=b_ready=1 → in_ready=0, a_valid=b_valid=0, both counts 0, data 0.
- Routing: send 0x11 (sel=0), 0x22 (sel=1), both sinks ready → a_data=0x11 one cycle after acceptance, b_data=0x22 one cycle after acceptance; a_count=1, b_count=1.
- Back-pressure isolation: a_ready=0, send 0x33 (sel=0) then 0x44 (sel=0) then 0x55 (sel=1) → 0x33 held on A, in_ready=0 for 0x44, in_ready=1 for 0x55, which emerges on B; release a_ready → 0x33 then 0x44 on A in order.
- Streaming: 16 consecutive words 0x00..0x0F to B with b_ready=1 → in_ready stays 1, b_data follows input by one cycle, b_count=16, no bubbles.
- Counter wrap: CNT_W=4, 17 transfers to A → a_count sequence reaches 15, then 0, then 1.
- Reset mid-stream: A full holding 0xAA, assert rst_n=0 for one edge with a_ready=1 → a_valid=0, a_count unchanged-to-0 (reset value), 0xAA never observed as transferred.

Source files
------------

// File: rtl/demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to2_stream
// Description : Registered 1-to-2 stream demultiplexer. Each input word is
//               steered by its select bit into a one-entry holding register
//               for channel A (sel=0) or channel B (sel=1). Every port uses a
//               valid/ready handshake. A stalled output only blocks words
//               addressed to it. Each channel counts its completed output
//               transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] a_data_o,
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic [WIDTH-1:0] b_data_o,
    output logic             b_valid_o,
    input  logic             b_ready_i,
    output logic [CNT_W-1:0] a_count_o,
    output logic [CNT_W-1:0] b_count_o
);

    // Per-channel holding register state: index 0 is channel A, 1 is B.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int c_NCH = 2;

    state_e           state_q [c_NCH];
    state_e           state_d [c_NCH];
    logic [WIDTH-1:0] data_q  [c_NCH];
    logic [WIDTH-1:0] data_d  [c_NCH];
    logic [CNT_W-1:0] cnt_q   [c_NCH];
    logic [CNT_W-1:0] cnt_d   [c_NCH];

    logic [1:0] w_ready;
    logic [1:0] w_drain;
    logic [1:0] w_load;
    logic       w_in_fire;

    assign w_ready = {b_ready_i, a_ready_i};

    // A channel drains when it holds a word and its sink accepts it.
    assign w_drain[0] = (state_q[0] == ST_FULL) && w_ready[0];
    assign w_drain[1] = (state_q[1] == ST_FULL) && w_ready[1];

    // Accept when the addressed slot is empty or is emptying this same cycle,
    // so a continuously drained channel sustains one word per clock.
    assign in_ready_o = rst_n && ((state_q[in_sel_i] == ST_EMPTY) || w_drain[in_sel_i]);
    assign w_in_fire  = in_valid_i && in_ready_o;
    assign w_load[0]  = w_in_fire && !in_sel_i;
    assign w_load[1]  = w_in_fire &&  in_sel_i;

    // Next-state, next-data and counter update for both channels.
    always_comb begin
        for (int c = 0; c < c_NCH; c++) begin
            state_d[c] = state_q[c];
            data_d[c]  = data_q[c];
            cnt_d[c]   = cnt_q[c];
            if (w_drain[c]) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end
            case (state_q[c])
                ST_EMPTY: begin
                    if (w_load[c]) begin
                        state_d[c] = ST_FULL;
                        data_d[c]  = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (w_load[c]) begin
                        // Only reachable together with a drain: refill in place.
                        data_d[c] = in_data_i;
                    end else if (w_drain[c]) begin
                        state_d[c] = ST_EMPTY;
                    end
                end
                default: state_d[c] = ST_EMPTY;
            endcase
        end
    end

    // State, data and counter registers; reset discards held words uncounted.
    always_ff @(posedge clk) begin
        for (int c = 0; c < c_NCH; c++) begin
            if (!rst_n) begin
                state_q[c] <= ST_EMPTY;
                data_q[c]  <= '0;
                cnt_q[c]   <= '0;
            end else begin
                state_q[c] <= state_d[c];
                data_q[c]  <= data_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    assign a_data_o  = data_q[0];
    assign a_valid_o = (state_q[0] == ST_FULL);
    assign a_count_o = cnt_q[0];
    assign b_data_o  = data_q[1];
    assign b_valid_o = (state_q[1] == ST_FULL);
    assign b_count_o = cnt_q[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to2_stream
// Description : Directed and randomized stimulus for demux_1to2_stream,
//               checked against a queue-based channel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to2_stream;

    localparam int c_WIDTH = 8;
    localparam int c_CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic [c_WIDTH-1:0] in_data_i;
    logic               in_sel_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [c_WIDTH-1:0] a_data_o;
    logic               a_valid_o;
    logic               a_ready_i;
    logic [c_WIDTH-1:0] b_data_o;
    logic               b_valid_o;
    logic               b_ready_i;
    logic [c_CNT_W-1:0] a_count_o;
    logic [c_CNT_W-1:0] b_count_o;

    demux_1to2_stream #(
        .WIDTH (c_WIDTH),
        .CNT_W (c_CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data_i),
        .in_sel_i   (in_sel_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_data_o   (a_data_o),
        .a_valid_o  (a_valid_o),
        .a_ready_i  (a_ready_i),
        .b_data_o   (b_data_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .a_count_o  (a_count_o),
        .b_count_o  (b_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    // Reference model: per channel, the ordered list of words accepted but
    // not yet delivered, plus a modulo transfer count.
    logic [c_WIDTH-1:0] m_q0[$];
    logic [c_WIDTH-1:0] m_q1[$];
    int                 m_cnt [2];
    bit                 m_zero[2];   // data known to be 0 (post-reset, no load yet)
    bit                 m_live;      // model state defined (after first reset edge)

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? m_q0.size() : m_q1.size();
    endfunction

    function automatic logic [c_WIDTH-1:0] qfront(input int ch);
        return (ch == 0) ? m_q0[0] : m_q1[0];
    endfunction

    // One clock cycle: drive inputs, check outputs against the model mid-cycle,
    // then advance the model across the rising edge.
    task automatic cyc(input bit rst, input bit vld, input bit sel,
                       input logic [c_WIDTH-1:0] dat, input bit ar, input bit br);
        bit ready [2];
        bit exp_rdy;
        bit fire;
        ready[0] = ar;
        ready[1] = br;
        rst_n      = rst;
        in_valid_i = vld;
        in_sel_i   = sel;
        in_data_i  = dat;
        a_ready_i  = ar;
        b_ready_i  = br;
        #1;
        if (!rst) begin
            exp_rdy = 1'b0;
        end else begin
            exp_rdy = (qsize(sel) == 0) || (qsize(sel) == 1 && ready[sel]);
        end
        if (m_live || !rst) check_eq("in_ready", {31'b0, in_ready_o}, {31'b0, exp_rdy});
        if (m_live) begin
            check_eq("a_valid", {31'b0, a_valid_o}, {31'b0, qsize(0) != 0});
            check_eq("b_valid", {31'b0, b_valid_o}, {31'b0, qsize(1) != 0});
            if (qsize(0) != 0)  check_eq("a_data", {24'b0, a_data_o}, {24'b0, qfront(0)});
            else if (m_zero[0]) check_eq("a_data_rst", {24'b0, a_data_o}, 32'h0);
            if (qsize(1) != 0)  check_eq("b_data", {24'b0, b_data_o}, {24'b0, qfront(1)});
            else if (m_zero[1]) check_eq("b_data_rst", {24'b0, b_data_o}, 32'h0);
            check_eq("a_count", {28'b0, a_count_o}, m_cnt[0]);
            check_eq("b_count", {28'b0, b_count_o}, m_cnt[1]);
        end
        @(posedge clk);
        if (!rst) begin
            m_q0.delete();
            m_q1.delete();
            m_cnt[0] = 0;  m_cnt[1] = 0;
            m_zero[0] = 1; m_zero[1] = 1;
            m_live = 1;
        end else begin
            fire = vld && exp_rdy;
            if (qsize(0) != 0 && ar) begin
                void'(m_q0.pop_front());
                m_cnt[0] = (m_cnt[0] + 1) % (1 << c_CNT_W);
                m_zero[0] = 0;
            end
            if (qsize(1) != 0 && br) begin
                void'(m_q1.pop_front());
                m_cnt[1] = (m_cnt[1] + 1) % (1 << c_CNT_W);
                m_zero[1] = 0;
            end
            if (fire) begin
                if (sel) begin m_q1.push_back(dat); m_zero[1] = 0; end
                else     begin m_q0.push_back(dat); m_zero[0] = 0; end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m_live = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_zero[0] = 0; m_zero[1] = 0;
        rst_n = 1'b0; in_valid_i = 1'b0; in_sel_i = 1'b0; in_data_i = '0;
        a_ready_i = 1'b0; b_ready_i = 1'b0;
        @(negedge clk);

        // Reset with input pressure and ready sinks.
        cyc(0, 1, 0, 8'h5A, 1, 1);
        cyc(0, 1, 1, 8'hA5, 1, 1);
        check_eq("rst_ready", {31'b0, in_ready_o}, 32'h0);

        // Routing.
        cyc(1, 1, 0, 8'h11, 1, 1);
        cyc(1, 1, 1, 8'h22, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        check_eq("route_acnt", {28'b0, a_count_o}, 32'd1);
        check_eq("route_bcnt", {28'b0, b_count_o}, 32'd1);

        // Back-pressure isolation: A stalled, B still flows.
        cyc(1, 1, 0, 8'h33, 0, 1);
        cyc(1, 1, 0, 8'h44, 0, 1);   // refused, source holds
        cyc(1, 1, 1, 8'h55, 0, 1);   // accepted onto B
        cyc(1, 1, 0, 8'h44, 0, 1);   // still refused
        cyc(1, 1, 0, 8'h44, 1, 1);   // 0x33 drains, 0x44 loads
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        check_eq("bp_acnt", {28'b0, a_count_o}, 32'd3);
        check_eq("bp_bcnt", {28'b0, b_count_o}, 32'd2);

        // Streaming to B.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 1, i[7:0], 1, 1);
            check_eq("stream_rdy", {31'b0, in_ready_o}, 32'h1);
        end
        cyc(1, 0, 0, 8'h00, 1, 1);
        check_eq("stream_bcnt", {28'b0, b_count_o}, 32'd2);  // 2 + 16 wraps mod 16

        // Counter wrap on A from a fresh reset.
        cyc(0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 17; i++) cyc(1, 1, 0, 8'h80 + i[7:0], 1, 0);
        cyc(1, 0, 0, 8'h00, 1, 0);
        check_eq("wrap_acnt", {28'b0, a_count_o}, 32'd1);

        // Reset mid-stream discards a held word without counting it.
        cyc(1, 1, 0, 8'hAA, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 0);
        check_eq("midrst_avalid", {31'b0, a_valid_o}, 32'h0);
        check_eq("midrst_acnt", {28'b0, a_count_o}, 32'h0);
        cyc(1, 0, 0, 8'h00, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, 1'($urandom),
                8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
